// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit, ALU and MAC: instruction opcodes, register
// fields, unit commands, bus sources and branch conditions.
package control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h1;
    localparam logic [3:0] OP_STORE  = 4'h2;
    localparam logic [3:0] OP_MOV    = 4'h3;
    localparam logic [3:0] OP_ALU    = 4'h4;
    localparam logic [3:0] OP_MAC    = 4'h5;
    localparam logic [3:0] OP_OUT    = 4'h6;
    localparam logic [3:0] OP_BRANCH = 4'h7;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [3:0] REG_ALU_ACC = 4'd0;
    localparam logic [3:0] REG_MAC_A   = 4'd1;
    localparam logic [3:0] REG_MAC_B   = 4'd2;

    localparam logic [3:0] ALU_NOP       = 4'hF;
    localparam logic [3:0] ALU_LOAD_ACC  = 4'h8;
    localparam logic [3:0] ALU_STORE_ACC = 4'h9;
    localparam logic [3:0] MAC_NOP       = 4'hF;
    localparam logic [3:0] MAC_FN_MAX    = 4'h2;
    localparam logic [3:0] MAC_LOAD_A    = 4'h4;
    localparam logic [3:0] MAC_LOAD_B    = 4'h5;
    localparam logic [3:0] MAC_STORE_A   = 4'h6;
    localparam logic [3:0] MAC_STORE_B   = 4'h7;

    localparam logic [2:0] BUS_MEM   = 3'd1;
    localparam logic [2:0] BUS_ALU   = 3'd2;
    localparam logic [2:0] BUS_MAC   = 3'd3;
    localparam logic [2:0] BUS_CONST = 3'd4;
    localparam logic [2:0] BUS_NONE  = 3'd5;

    localparam logic [3:0] COND_EQ   = 4'd0;
    localparam logic [3:0] COND_NEQ  = 4'd1;
    localparam logic [3:0] COND_GT   = 4'd2;
    localparam logic [3:0] COND_GTEQ = 4'd3;
    localparam logic [3:0] COND_LT   = 4'd4;
    localparam logic [3:0] COND_LTEQ = 4'd5;

    typedef struct packed {
        logic [3:0] alu;
        logic [3:0] mac;
    } cmd_t;

    // Register load from the bus (MOV, LOAD write-back); unknown fields issue nothing.
    function automatic cmd_t load_cmd(input logic [3:0] field);
        case (field)
            REG_ALU_ACC: return '{alu: ALU_LOAD_ACC, mac: MAC_NOP};
            REG_MAC_A:   return '{alu: ALU_NOP, mac: MAC_LOAD_A};
            REG_MAC_B:   return '{alu: ALU_NOP, mac: MAC_LOAD_B};
            default:     return '{alu: ALU_NOP, mac: MAC_NOP};
        endcase
    endfunction

    function automatic cmd_t store_cmd(input logic [3:0] field);
        case (field)
            REG_ALU_ACC: return '{alu: ALU_STORE_ACC, mac: MAC_NOP};
            REG_MAC_A:   return '{alu: ALU_NOP, mac: MAC_STORE_A};
            REG_MAC_B:   return '{alu: ALU_NOP, mac: MAC_STORE_B};
            default:     return '{alu: ALU_NOP, mac: MAC_NOP};
        endcase
    endfunction

    function automatic logic [2:0] store_src(input logic [3:0] field);
        case (field)
            REG_ALU_ACC:          return BUS_ALU;
            REG_MAC_A, REG_MAC_B: return BUS_MAC;
            default:              return BUS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_branch.sv
// Combinational branch condition evaluation from the accumulator zero/overflow flags.
module branch_unit
    import control_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       acc_zero,
    input  logic       acc_overflow,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ:   taken = acc_zero;
            COND_NEQ:  taken = !acc_zero;
            COND_GT:   taken = !acc_zero && !acc_overflow;
            COND_GTEQ: taken = !acc_overflow;
            COND_LT:   taken = acc_overflow;
            COND_LTEQ: taken = acc_overflow || acc_zero;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/write-back with Moore-decoded
// commands to the ALU, MAC, data bus and memory.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  start,
    input  logic [15:0]           inst_in,
    input  logic                  acc_zero,
    input  logic                  acc_overflow,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [3:0]            alu_opcode,
    output logic [3:0]            mac_opcode,
    output logic [2:0]            bus_sel,
    output logic [DATA_WIDTH-1:0] const_out,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  out_we,
    output logic                  halted,
    output logic [2:0]            state_dbg
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [15:0]           ir;
    logic [3:0]            opcode;
    logic [3:0]            field;
    logic [7:0]            imm;
    logic                  branch_taken;
    cmd_t                  ld_cmd;
    cmd_t                  st_cmd;

    assign opcode = ir[15:12];
    assign field  = ir[11:8];
    assign imm    = ir[7:0];
    assign ld_cmd = load_cmd(field);
    assign st_cmd = store_cmd(field);

    branch_unit u_branch (
        .cond         (field),
        .acc_zero     (acc_zero),
        .acc_overflow (acc_overflow),
        .taken        (branch_taken)
    );

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= '0;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                // Instruction memory has one cycle of read latency, so the word for pc is valid here.
                ST_DECODE: begin
                    ir    <= inst_in;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opcode == OP_HLT) begin
                        state <= ST_HALT;
                    end else begin
                        if (opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_OUT)
                            state <= ST_WB;
                        else
                            state <= ST_FETCH;
                        if (opcode == OP_BRANCH && branch_taken)
                            pc <= ADDR_WIDTH'(imm);
                        else
                            pc <= pc + ADDR_WIDTH'(1);
                    end
                end
                ST_WB:   state <= ST_FETCH;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Commands depend only on the state and instruction register.
    always_comb begin
        alu_opcode = ALU_NOP;
        mac_opcode = MAC_NOP;
        bus_sel    = BUS_NONE;
        const_out  = '0;
        mem_we     = 1'b0;
        out_we     = 1'b0;
        case (state)
            ST_EXEC: begin
                case (opcode)
                    OP_MOV: begin
                        bus_sel    = BUS_CONST;
                        const_out  = DATA_WIDTH'(imm);
                        alu_opcode = ld_cmd.alu;
                        mac_opcode = ld_cmd.mac;
                    end
                    OP_LOAD: bus_sel = BUS_MEM;
                    OP_STORE, OP_OUT: begin
                        alu_opcode = st_cmd.alu;
                        mac_opcode = st_cmd.mac;
                    end
                    OP_ALU: alu_opcode = field[3] ? ALU_NOP : field;
                    OP_MAC: mac_opcode = (field <= MAC_FN_MAX) ? field : MAC_NOP;
                    default: ;
                endcase
            end
            ST_WB: begin
                case (opcode)
                    OP_LOAD: begin
                        bus_sel    = BUS_MEM;
                        alu_opcode = ld_cmd.alu;
                        mac_opcode = ld_cmd.mac;
                    end
                    OP_STORE: begin
                        bus_sel = store_src(field);
                        mem_we  = 1'b1;
                    end
                    OP_OUT: begin
                        bus_sel = store_src(field);
                        out_we  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign pc_out    = pc;
    assign mem_addr  = ADDR_WIDTH'(imm);
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, datapath and immediate width.
REQ-002 Parameter ADDR_WIDTH, default 8, program counter and memory address width.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port a_reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, level; begins execution from address 0 when in IDLE or HALT.
REQ-006 Port inst_in, input, 16, instruction word: [15:12] opcode, [11:8] field, [7:0] address or immediate.
REQ-007 Ports acc_zero and acc_overflow, inputs, 1 each, ALU accumulator flags.
REQ-008 Port pc_out, output, ADDR_WIDTH, instruction fetch address.
REQ-009 Ports alu_opcode and mac_opcode, outputs, 4 each, commands to the ALU and MAC.
REQ-010 Port bus_sel, output, 3, shared data-bus source select.
REQ-011 Port const_out, output, DATA_WIDTH, immediate driven onto the bus.
REQ-012 Ports mem_addr (ADDR_WIDTH), mem_we (1), out_we (1), outputs: data-memory address, memory write strobe and output-register load.
REQ-013 Port halted, output, 1, high in HALT.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-015 IDLE/HALT with start=1 -> FETCH with pc=0; start SHALL be ignored in all other states.
REQ-016 FETCH -> DECODE; DECODE latches inst_in into the instruction register (memory read latency 1) -> EXEC.
REQ-017 EXEC -> WB for LOAD, STORE and OUT; EXEC -> HALT for HLT; otherwise EXEC -> FETCH.
REQ-018 WB -> FETCH.
REQ-019 pc SHALL advance by 1 (wrapping from all-ones to 0) on leaving EXEC, except on a taken branch or HLT.
REQ-020 Defaults whenever not driven by REQ-021..028: alu_opcode=0xF, mac_opcode=0xF, bus_sel=5, const_out=0, mem_we=0, out_we=0, mem_addr=imm.
REQ-021 MOV (op 3): EXEC drives bus_sel=4 and const_out=imm; field 0/1/2 issues alu 0x8, mac 0x4 or mac 0x5 respectively.
REQ-022 LOAD (op 1): EXEC drives bus_sel=1 with mem_addr=imm; WB keeps bus_sel=1 and issues the field-selected register load as in REQ-021.
REQ-023 STORE (op 2): EXEC issues alu 0x9, mac 0x6 or mac 0x7 for field 0/1/2; WB drives bus_sel 2 (field 0) or 3 (fields 1/2) with mem_we=1 for exactly one cycle.
REQ-024 OUT (op 6): identical to STORE, except WB asserts out_we instead of mem_we.
REQ-025 ALU (op 4): EXEC sets alu_opcode=field if field<=7, else 0xF; MAC (op 5): EXEC sets mac_opcode=field if field<=2, else 0xF.
REQ-026 BRANCH (op 7): EXEC evaluates the condition and loads pc<=imm when taken.
REQ-027 Branch conditions: EQ=Z, NEQ=!Z, GT=!Z&!V, GTEQ=!V, LT=V, LTEQ=V|Z; fields 6..15 SHALL NOT be taken.
REQ-028 NOOP (op 0) and undefined opcodes 8..14 SHALL behave as NOOP; field values 3..15 in MOV/LOAD/STORE/OUT SHALL suppress the register command.
REQ-029 Instruction latency SHALL be 3 cycles (FETCH..EXEC), or 4 cycles for LOAD/STORE/OUT.
REQ-030 Outputs SHALL be Moore-decoded from the state and instruction register only.

Reset
REQ-031 Asserting a_reset_n low SHALL immediately force IDLE, pc=0, instruction register=0 and all outputs to the REQ-020 defaults, in any state including mid-WB.
REQ-032 After reset, no command SHALL issue until start is sampled high.

Structure
REQ-033 ALU/MAC opcodes, bus-select codes, instruction opcodes, register fields and branch conditions SHALL live in one shared constants include used by control_unit, alu and mac.
REQ-034 Condition evaluation SHALL be a combinational sub-module named branch_unit.

Verification
REQ-035 Reset, start, mem[0]=0x3005 -> third cycle: bus_sel=4, const_out=0x05, alu_opcode=0x8; then pc=1.
REQ-036 0x1120 -> EXEC: bus_sel=1, mem_addr=0x20; WB: mac_opcode=0x4; 4 cycles total.
REQ-037 0x7040 with acc_zero=1 -> pc=0x40; the same with acc_zero=0 -> pc=previous+1; 0x7440 with acc_overflow=1 -> taken.
REQ-038 0x2010 -> EXEC: alu_opcode=0x9; WB: bus_sel=2, mem_addr=0x10, mem_we=1 for one cycle; reset asserted mid-WB -> mem_we=0 immediately, IDLE, pc=0.
REQ-039 NOOP at pc=0xFF -> pc=0x00; 0xF000 -> halted=1, outputs at defaults, pc frozen; start -> FETCH at pc=0.
